memory_arbiter: RTL

Shares the single 128-bit main-memory port between the instruction-cache refill FSM and the data-cache refill/writeback FSM. Each cache raises a level request and waits for a one-cycle ready pulse with a 128-bit block. The arbiter gives the data cache fixed priority, with an anti-starvation limit for instruction fetch. A programmable hold-off window masks the trailing request cycle that both caches keep asserting after their ready pulse.

---
 rtl/memory_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Shares the single 128-bit main-memory port between the icache refill FSM
//   and the dcache refill/writeback FSM. The dcache has fixed priority. After
//   MAX_DC_CONSEC back-to-back dcache grants with an icache request pending,
//   the icache is forced through. A HOLDOFF-cycle window after every
//   completed transfer masks the trailing request cycle that each cache
//   keeps asserting after its ready pulse.
//
// Ports
//   clock, reset              system clock; asynchronous active-high reset
//   ic_req/ic_addr            icache read request (level) and miss address
//   ic_ready/ic_block         one-cycle completion pulse and refill block
//   dc_req/dc_we/dc_addr      dcache request (level), direction, address
//   dc_wdata                  dcache writeback block
//   dc_ready/dc_rdata         one-cycle completion pulse and read block
//   mem_req/mem_we/mem_addr   memory request (held until mem_ack), direction,
//   mem_wdata                 16-byte-aligned address and write block
//   mem_rdata/mem_ack         memory read block and completion
//   busy                      arbiter not idle
//   owner                     00 none, 01 icache, 10 dcache
module memory_arbiter #(
  parameter int unsigned MAX_DC_CONSEC = 4,
  parameter int unsigned HOLDOFF       = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ic_req,
  input  logic [31:0]  ic_addr,
  output logic         ic_ready,
  output logic [127:0] ic_block,
  input  logic         dc_req,
  input  logic         dc_we,
  input  logic [31:0]  dc_addr,
  input  logic [127:0] dc_wdata,
  output logic         dc_ready,
  output logic [127:0] dc_rdata,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ack,
  output logic         busy,
  output logic [1:0]   owner
);

  localparam logic [3:0] STARV_MAX = 4'(MAX_DC_CONSEC);
  localparam logic [2:0] HOLD_LOAD = 3'(HOLDOFF);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IC = 2'd1,
    GRANT_DC = 2'd2,
    HOLD     = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] starv_cnt;
  logic [2:0] hold_cnt;
  logic       pick_ic;
  logic       pick_dc;
  logic       xfer_done;

  // Byte-offset bits are dropped by block alignment.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ic_addr[3:0], dc_addr[3:0]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pick_ic    = 1'b0;
    pick_dc    = 1'b0;
    xfer_done  = 1'b0;
    case (state)
      IDLE: begin
        if (ic_req && dc_req) begin
          if (starv_cnt >= STARV_MAX) begin
            pick_ic = 1'b1;
          end else begin
            pick_dc = 1'b1;
          end
        end else if (ic_req) begin
          pick_ic = 1'b1;
        end else if (dc_req) begin
          pick_dc = 1'b1;
        end
        if (pick_ic) begin
          state_next = GRANT_IC;
        end else if (pick_dc) begin
          state_next = GRANT_DC;
        end
      end
      GRANT_IC, GRANT_DC: begin
        // mem_req is high in every grant cycle, including the first one,
        // so an ack coinciding with the rising request completes it.
        if (mem_ack && mem_req) begin
          xfer_done  = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt <= 3'd1) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ic_ready  <= 1'b0;
      dc_ready  <= 1'b0;
      ic_block  <= '0;
      dc_rdata  <= '0;
      owner     <= 2'b00;
      busy      <= 1'b0;
      starv_cnt <= '0;
      hold_cnt  <= '0;
    end else begin
      ic_ready <= 1'b0;
      dc_ready <= 1'b0;
      busy     <= (state_next != IDLE);

      if (pick_ic) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= {ic_addr[31:4], 4'h0};
        owner     <= 2'b01;
        starv_cnt <= '0;
      end

      if (pick_dc) begin
        mem_req   <= 1'b1;
        mem_we    <= dc_we;
        mem_addr  <= {dc_addr[31:4], 4'h0};
        mem_wdata <= dc_wdata;
        owner     <= 2'b10;
        if (!ic_req) begin
          starv_cnt <= '0;
        end else if (starv_cnt < STARV_MAX) begin
          starv_cnt <= starv_cnt + 4'd1;
        end
      end

      if (xfer_done) begin
        mem_req  <= 1'b0;
        mem_we   <= 1'b0;
        owner    <= 2'b00;
        hold_cnt <= HOLD_LOAD;
        if (state == GRANT_IC) begin
          ic_ready <= 1'b1;
          ic_block <= mem_rdata;
        end else begin
          dc_ready <= 1'b1;
          // mem_we still carries the latched direction of this transfer.
          if (!mem_we) begin
            dc_rdata <= mem_rdata;
          end
        end
      end else if (state == HOLD) begin
        hold_cnt <= hold_cnt - 3'd1;
      end
    end
  end

endmodule
